// File: rtl/sum_feeder_pkg.sv
// rtl/sum_feeder_pkg.sv - shared encodings and constants for the sum feeder
package sum_feeder_pkg;

  localparam int FLOAT_DATA_WIDTH_DEF = 32;
  localparam logic [31:0] FLOAT_ZERO = 32'h0000_0000;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_CLEAR  = 3'd1;
  localparam logic [2:0] ST_LOAD_A = 3'd2;
  localparam logic [2:0] ST_LOAD_B = 3'd3;
  localparam logic [2:0] ST_ISSUE  = 3'd4;
  localparam logic [2:0] ST_WAIT   = 3'd5;
  localparam logic [2:0] ST_FINISH = 3'd6;

endpackage

// File: rtl/sum_feeder_float_fifo.sv
// rtl/sum_feeder_float_fifo.sv - small power-of-two FIFO holding float operands
module float_fifo
  import sum_feeder_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int WIDTH = FLOAT_DATA_WIDTH_DEF,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty,
  output logic [CW-1:0]    count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             push_ok;
  logic             pop_ok;

  assign full     = (count == CW'(DEPTH));
  assign empty    = (count == '0);
  assign push_ok  = push && !full;
  assign pop_ok   = pop && !empty;
  assign pop_data = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wr_ptr] <= push_data;
    end
  end

  // The count register is what separates full from empty; pointers wrap naturally.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop_ok) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push_ok, pop_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/sum_feeder.sv
// rtl/sum_feeder.sv - pairs buffered floats and schedules them onto the accumulating adder
module sum_feeder
  import sum_feeder_pkg::*;
#(
  parameter int FLOAT_DATA_WIDTH = FLOAT_DATA_WIDTH_DEF,
  parameter int FIFO_DEPTH = 4,
  parameter int CNT_WIDTH = 10,
  parameter logic [CNT_WIDTH-1:0] TIMEOUT = 10'd63
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        frame_start,
  input  logic [CNT_WIDTH-1:0]        frame_len,
  input  logic                        in_valid,
  input  logic [FLOAT_DATA_WIDTH-1:0] in_data,
  output logic                        in_ready,
  output logic                        add_rst,
  output logic                        add_start,
  output logic                        add_clk_en,
  output logic [FLOAT_DATA_WIDTH-1:0] add_one,
  output logic [FLOAT_DATA_WIDTH-1:0] add_two,
  input  logic                        add_done,
  input  logic [FLOAT_DATA_WIDTH-1:0] add_total,
  input  logic                        add_working,
  output logic                        sum_valid,
  output logic [FLOAT_DATA_WIDTH-1:0] sum_out,
  output logic                        busy,
  output logic                        timeout_err
);

  localparam int FCW = $clog2(FIFO_DEPTH) + 1;

  logic [2:0]                  state;
  logic [CNT_WIDTH-1:0]        remaining;
  logic [CNT_WIDTH-1:0]        tcnt;
  logic [CNT_WIDTH-1:0]        tcnt_next;
  logic [CNT_WIDTH-1:0]        pair_cnt;
  logic                        pair_two;
  logic                        to_rst_q;
  logic                        last_term;
  logic                        fifo_push;
  logic                        fifo_pop;
  logic                        fifo_full;
  logic                        fifo_empty;
  logic [FCW-1:0]              fifo_count;
  logic [FLOAT_DATA_WIDTH-1:0] fifo_head;

  float_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (FLOAT_DATA_WIDTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (fifo_push),
    .push_data (in_data),
    .pop       (fifo_pop),
    .pop_data  (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  assign last_term = (remaining == CNT_WIDTH'(1));
  assign tcnt_next = tcnt + 1'b1;
  assign pair_cnt  = pair_two ? CNT_WIDTH'(2) : CNT_WIDTH'(1);

  assign in_ready  = !fifo_full;
  assign fifo_push = in_valid && !fifo_full;
  assign fifo_pop  = ((state == ST_LOAD_A) && !fifo_empty && !add_working) ||
                     ((state == ST_LOAD_B) && !last_term && (fifo_count != '0));

  // Strobes decode straight from the state register so reset clears them at once.
  assign add_rst    = (state == ST_CLEAR) || to_rst_q;
  assign add_start  = (state == ST_ISSUE);
  assign add_clk_en = (state == ST_ISSUE);
  assign sum_valid  = (state == ST_FINISH);
  assign busy       = (state != ST_IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= ST_IDLE;
      remaining   <= '0;
      tcnt        <= '0;
      pair_two    <= 1'b0;
      to_rst_q    <= 1'b0;
      add_one     <= '0;
      add_two     <= '0;
      sum_out     <= '0;
      timeout_err <= 1'b0;
    end else begin
      to_rst_q <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (frame_start) begin
            remaining <= frame_len;
            state     <= ST_CLEAR;
          end
        end
        ST_CLEAR: begin
          if (remaining == '0) begin
            sum_out <= '0;
            state   <= ST_FINISH;
          end else begin
            state <= ST_LOAD_A;
          end
        end
        ST_LOAD_A: begin
          if (fifo_pop) begin
            add_one <= fifo_head;
            state   <= ST_LOAD_B;
          end
        end
        ST_LOAD_B: begin
          // An odd final term is paired with zero instead of waiting for more data.
          if (last_term) begin
            add_two  <= FLOAT_DATA_WIDTH'(FLOAT_ZERO);
            pair_two <= 1'b0;
            state    <= ST_ISSUE;
          end else if (fifo_pop) begin
            add_two  <= fifo_head;
            pair_two <= 1'b1;
            state    <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          tcnt  <= '0;
          state <= ST_WAIT;
        end
        ST_WAIT: begin
          if (add_done) begin
            sum_out   <= add_total;
            remaining <= remaining - pair_cnt;
            state     <= (remaining == pair_cnt) ? ST_FINISH : ST_LOAD_A;
          end else if (tcnt_next == TIMEOUT) begin
            timeout_err <= 1'b1;
            to_rst_q    <= 1'b1;
            state       <= ST_IDLE;
          end else begin
            tcnt <= tcnt_next;
          end
        end
        ST_FINISH: begin
          state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sum_feeder.sv
// tb/tb_sum_feeder.sv - scoreboard bench for the sum feeder with a simple adder model
module tb_sum_feeder;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        frame_start = 1'b0;
  logic [9:0]  frame_len = '0;
  logic        in_valid = 1'b0;
  logic [31:0] in_data = '0;
  logic        add_done = 1'b0;
  logic        add_working = 1'b0;
  logic [31:0] add_total = '0;
  logic        in_ready, add_rst, add_start, add_clk_en, sum_valid, busy, timeout_err;
  logic [31:0] add_one, add_two, sum_out;

  int          n_cmp = 0;
  int          n_bad = 0;
  logic [63:0] exp_pair[$];
  logic [31:0] exp_sum[$];
  logic        model_en = 1'b1;
  logic [31:0] model_total = '0;
  int          dly = 0;
  int          cyc = 0;
  int          last_done_cyc = 0;
  int          last_sum_cyc = 0;

  always #5 clk = ~clk;

  sum_feeder dut (
    .clk         (clk),
    .rst         (rst),
    .frame_start (frame_start),
    .frame_len   (frame_len),
    .in_valid    (in_valid),
    .in_data     (in_data),
    .in_ready    (in_ready),
    .add_rst     (add_rst),
    .add_start   (add_start),
    .add_clk_en  (add_clk_en),
    .add_one     (add_one),
    .add_two     (add_two),
    .add_done    (add_done),
    .add_total   (add_total),
    .add_working (add_working),
    .sum_valid   (sum_valid),
    .sum_out     (sum_out),
    .busy        (busy),
    .timeout_err (timeout_err)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    n_cmp++;
    n_bad++;
    $display("FAIL %s: event missing or unexpected", name);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_val(input logic [31:0] v);
    int n = 0;
    in_valid = 1'b1;
    in_data  = v;
    while (in_ready !== 1'b1 && n < 100) begin
      tick();
      n++;
    end
    if (in_ready !== 1'b1) fail_now("push_wait");
    tick();
    in_valid = 1'b0;
  endtask

  task automatic start_frame(input logic [9:0] len);
    frame_len   = len;
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
  endtask

  task automatic wait_start(input int bound);
    int n = 0;
    while (add_start !== 1'b1 && n < bound) begin
      tick();
      n++;
    end
    if (add_start !== 1'b1) fail_now("wait_add_start");
  endtask

  task automatic wait_sum(input int bound);
    int n = 0;
    while (sum_valid !== 1'b1 && n < bound) begin
      tick();
      n++;
    end
    if (sum_valid !== 1'b1) fail_now("wait_sum_valid");
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Adder model: busy for a few cycles after each issue, then reports the programmed total.
  always @(posedge clk) begin
    if (rst) begin
      add_done    <= 1'b0;
      add_working <= 1'b0;
      dly         <= 0;
    end else begin
      add_done <= 1'b0;
      if (add_start && model_en) begin
        add_working <= 1'b1;
        dly         <= 2;
      end else if (add_working && model_en) begin
        if (dly == 0) begin
          add_done    <= 1'b1;
          add_total   <= model_total;
          add_working <= 1'b0;
        end else begin
          dly <= dly - 1;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (rst === 1'b0) begin
      if (add_done) last_done_cyc = cyc;
      if (add_start) begin
        check("clk_en_with_start", add_clk_en, 1'b1);
        if (exp_pair.size() == 0) fail_now("unexpected_add_start");
        else check("operand_pair", {add_one, add_two}, exp_pair.pop_front());
      end
      if (sum_valid) begin
        last_sum_cyc = cyc;
        if (exp_sum.size() == 0) fail_now("unexpected_sum_valid");
        else check("sum_out", sum_out, exp_sum.pop_front());
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    #1 rst = 1'b1;
    #2;
    check("rst_in_ready", in_ready, 1'b1);
    check("rst_busy", busy, 1'b0);
    check("rst_add_rst", add_rst, 1'b0);
    check("rst_add_start", add_start, 1'b0);
    check("rst_sum_valid", sum_valid, 1'b0);
    check("rst_timeout_err", timeout_err, 1'b0);
    check("rst_sum_out", sum_out, 32'h0);
    check("rst_add_one", add_one, 32'h0);
    tick();
    tick();
    rst = 1'b0;
    tick();

    // four terms, two full pairs
    exp_pair.push_back({32'h3F80_0000, 32'h4000_0000});
    exp_pair.push_back({32'h4040_0000, 32'h4080_0000});
    exp_sum.push_back(32'h4120_0000);
    model_total = 32'h4120_0000;
    push_val(32'h3F80_0000);
    push_val(32'h4000_0000);
    push_val(32'h4040_0000);
    push_val(32'h4080_0000);
    start_frame(10'd4);
    check("clear_add_rst", add_rst, 1'b1);
    n = 1;
    while (add_start !== 1'b1 && n < 50) begin
      tick();
      n++;
    end
    check("issue_latency", n, 4);
    wait_sum(200);
    @(negedge clk);
    #1;
    check("done_to_sum_gap", last_sum_cyc - last_done_cyc, 1);
    tick();

    // odd length pads last pair with zero
    exp_pair.push_back({32'h3F80_0000, 32'h4000_0000});
    exp_pair.push_back({32'h4040_0000, 32'h0000_0000});
    exp_sum.push_back(32'h40C0_0000);
    model_total = 32'h40C0_0000;
    push_val(32'h3F80_0000);
    push_val(32'h4000_0000);
    push_val(32'h4040_0000);
    start_frame(10'd3);
    wait_sum(200);
    tick();

    // empty frame
    exp_sum.push_back(32'h0);
    start_frame(10'd0);
    check("len0_add_rst", add_rst, 1'b1);
    check("len0_early_sum", sum_valid, 1'b0);
    tick();
    check("len0_sum_valid", sum_valid, 1'b1);
    check("len0_add_rst_done", add_rst, 1'b0);
    tick();
    check("len0_idle", busy, 1'b0);

    // fill FIFO, hold off the fifth value, surplus carries into next frame
    push_val(32'h4100_0000);
    push_val(32'h4110_0000);
    push_val(32'h4120_0000);
    push_val(32'h4130_0000);
    check("full_in_ready", in_ready, 1'b0);
    in_valid = 1'b1;
    in_data  = 32'h4140_0000;
    tick();
    tick();
    tick();
    check("held_in_ready", in_ready, 1'b0);
    exp_pair.push_back({32'h4100_0000, 32'h4110_0000});
    exp_sum.push_back(32'h4188_0000);
    model_total = 32'h4188_0000;
    start_frame(10'd2);
    n = 0;
    while (in_ready !== 1'b1 && n < 50) begin
      tick();
      n++;
    end
    if (in_ready !== 1'b1) fail_now("fifth_push_wait");
    tick();
    in_valid = 1'b0;
    wait_sum(200);
    tick();
    exp_pair.push_back({32'h4120_0000, 32'h4130_0000});
    exp_pair.push_back({32'h4140_0000, 32'h0000_0000});
    exp_sum.push_back(32'h4204_0000);
    model_total = 32'h4204_0000;
    start_frame(10'd3);
    wait_sum(200);
    tick();

    // adder never completes
    model_en = 1'b0;
    exp_pair.push_back({32'h3F80_0000, 32'h0000_0000});
    push_val(32'h3F80_0000);
    start_frame(10'd1);
    wait_start(50);
    n = 0;
    while (timeout_err !== 1'b1 && n < 200) begin
      tick();
      n++;
    end
    check("timeout_latency", n, 64);
    check("timeout_err", timeout_err, 1'b1);
    check("timeout_add_rst", add_rst, 1'b1);
    check("timeout_busy", busy, 1'b0);
    tick();
    check("timeout_add_rst_pulse", add_rst, 1'b0);
    check("timeout_sticky", timeout_err, 1'b1);

    // reset while waiting on the adder
    exp_pair.push_back({32'h4000_0000, 32'h4040_0000});
    push_val(32'h4000_0000);
    push_val(32'h4040_0000);
    push_val(32'h4080_0000);
    start_frame(10'd2);
    wait_start(50);
    tick();
    tick();
    check("wait_busy", busy, 1'b1);
    rst = 1'b1;
    #1;
    check("arst_busy", busy, 1'b0);
    check("arst_timeout_err", timeout_err, 1'b0);
    check("arst_add_rst", add_rst, 1'b0);
    check("arst_in_ready", in_ready, 1'b1);
    check("arst_operands", {add_one, add_two}, 64'h0);
    check("arst_sum_out", sum_out, 32'h0);
    tick();
    rst = 1'b0;
    model_en = 1'b1;
    tick();
    exp_pair.push_back({32'h40A0_0000, 32'h0000_0000});
    exp_sum.push_back(32'h40A0_0000);
    model_total = 32'h40A0_0000;
    start_frame(10'd1);
    for (int i = 0; i < 10; i++) tick();
    check("empty_after_rst_stall", busy, 1'b1);
    push_val(32'h40A0_0000);
    wait_sum(200);

    for (int i = 0; i < 5; i++) tick();
    check("pairs_drained", exp_pair.size(), 0);
    check("sums_drained", exp_sum.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
